// File: rtl/pulse_event_counter.sv
//============================================================================
// Module   : pulse_event_counter
// Brief    : Synchronises an asynchronous pulse train, counts rising edges,
//            and raises sticky threshold-interrupt and overflow flags.
//            Optional build macro PEC_SATURATE_EN: saturate instead of wrap.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module pulse_event_counter #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  input  logic         clear,
  input  logic [W-1:0] threshold,
  input  logic         ack,
  output logic [W-1:0] count,
  output logic         irq,
  output logic         overflow,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] C_MAX  = {W{1'b1}};
  localparam logic [W-1:0] C_ZERO = {W{1'b0}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [W-1:0]           r_count;
  logic                   r_irq;
  logic                   r_ovf;
  state_t                 r_state;

  logic                   w_edge;
  logic                   w_inc;
  logic                   w_hit;
  logic [W-1:0]           w_count_nxt;
  logic                   w_irq_nxt;
  logic                   w_ovf_nxt;
  state_t                 w_state_nxt;

  // pulse_in is asynchronous: only the last synchroniser stage is trusted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_inc       = 1'b0;
    if (w_edge) begin
`ifdef PEC_SATURATE_EN
      if (r_count == C_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + C_ONE;
        w_inc       = 1'b1;
      end
`else
      w_count_nxt = r_count + C_ONE;
      w_inc       = 1'b1;
      if (r_count == C_MAX) begin
        w_ovf_nxt = 1'b1;
      end
`endif
    end
    // Compare only on increment edges so a lowered threshold stays quiet
    w_hit = w_inc && (threshold != C_ZERO) && (w_count_nxt == threshold);
    if (w_hit) begin
      w_irq_nxt = 1'b1;
    end else if (ack) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq;
    end
    if (clear) begin
      w_count_nxt = C_ZERO;
      w_ovf_nxt   = 1'b0;
      w_irq_nxt   = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt = w_irq_nxt ? ST_ALERT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_irq_nxt) begin
          w_state_nxt = ST_ALERT;
        end
      end
      ST_ALERT: begin
        if (!w_irq_nxt) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= C_ZERO;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_count <= w_count_nxt;
      r_irq   <= w_irq_nxt;
      r_ovf   <= w_ovf_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign count    = r_count;
  assign irq      = r_irq;
  assign overflow = r_ovf;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: doc/pulse_event_counter.md
Name: pulse_event_counter

Overview:
- Downstream consumer of the pulse-transition-detector output: takes its narrow, clock-asynchronous pulse train, synchronises it into the system clock domain, and counts rising edges.
- Raises a sticky threshold interrupt with an acknowledge handshake.
- Flags counter overflow.
- Used to measure and alarm on pulse-generator activity in the basic-logic test designs.

Parameters:
- W, 8, counter and threshold width in bits (W >= 2).
- SYNC_STAGES, 2, flip-flops in the pulse_in synchroniser chain (>= 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pulse_in  input  1  asynchronous pulse from the upstream detector.
- clear  input  1  synchronous clear of count, overflow, irq, state.
- threshold  input  W  count value that raises irq; 0 disables irq.
- ack  input  1  interrupt acknowledge; clears irq.
- count  output  W  number of rising edges detected since reset or clear.
- irq  output  1  sticky threshold-reached flag.
- overflow  output  1  sticky counter-overflow flag.
- state  output  2  FSM state: 0 IDLE, 1 RUN, 2 ALERT.

Behaviour:
- Reset (rst=1, any time, independent of clk):
  - count=0, irq=0, overflow=0, state=IDLE.
  - Synchroniser flops and edge-history flop cleared to 0.
  - Takes effect immediately, including mid-count or in ALERT.
  - After rst deasserts, a pulse_in already high counts as one edge once synchronised.
- Synchroniser and edge detection:
  - SYNC_STAGES-flop chain feeds an edge detector: edge = sync_out & ~prev.
  - prev is a registered copy of sync_out.
- Latency: count increments on the SYNC_STAGES-th rising clk edge after the first edge that samples pulse_in=1. Default is 2 edges.
- Input timing:
  - pulse_in high and low times must each span at least one clk rising edge.
  - Narrower pulses may be missed; this is not an error.
  - A level held high counts once.
- Counting:
  - +1 per detected edge, modulo 2^W by default.
  - Wrap from 2^W-1 to 0 sets overflow (sticky).
- irq:
  - Set on the same edge on which count becomes equal to threshold (threshold != 0).
  - Cleared on the edge where ack=1 and no new threshold hit occurs.
  - If ack and a new hit coincide, irq stays 1.
  - ack with irq=0 has no effect.
- clear:
  - Synchronous; count=0, irq=0, overflow=0, state=IDLE on the next edge.
  - Overrides a coincident edge, hit, or ack; that edge is discarded.
  - Does not reset the synchroniser.
- FSM:
  - IDLE -> RUN on first detected edge.
  - RUN -> ALERT when irq sets.
  - ALERT -> RUN on ack (irq cleared).
  - Any state -> IDLE on clear.
  - Counting continues in ALERT.
  - A wrap whose post-wrap count equals threshold re-raises irq.
- threshold changes:
  - Take effect immediately; the compare is evaluated only on increment edges.
  - Lowering threshold below the current count raises no irq until after a wrap.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PEC_SATURATE_EN.
- Defined:
  - count saturates at 2^W-1; further edges leave count unchanged.
  - The first attempted increment at max sets overflow.
  - irq cannot re-fire after saturation except via clear.
- Undefined: modulo-2^W wrap as described above.
- Ports identical in both builds.

Test Plan:
- Reset: rst=1 with pulse_in toggling, then released -> count=0, irq=0, overflow=0, state=0 throughout rst. A pulse high across edge N gives count=1 visible after edge N+2.
- Threshold handshake: threshold=5, send 5 pulses (each 3 clk high, 3 low) -> irq=1 and state=2 on the edge count becomes 5. ack=1 for one cycle -> irq=0, state=1. Pulses 6..7 -> count=7, irq stays 0.
- Wrap (W=8, macro undefined): threshold=0, 257 pulses -> count=1, overflow=1, irq=0. clear -> count=0, overflow=0, state=0.
- Saturate (PEC_SATURATE_EN, W=8): 300 pulses -> count=255, overflow=1 set when pulse 256 arrives.
- Simultaneous events:
  - clear asserted on the same edge an edge is detected -> count=0.
  - ack on the same edge count hits threshold=3 -> irq remains 1.
- Async reset mid-ALERT: count=5, irq=1, rst pulsed for 3 ns between clk edges -> all outputs 0 immediately, without waiting for a clk edge.
